// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// write-back requesters; registers the winning destination/data toward the register file.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_reg,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_stall,
    output logic                 RegWrite,
    output logic [AW-1:0]        WriteReg,
    output logic [DW-1:0]        WriteData,
    output logic [15:0]          wr_count
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    logic [AW-1:0] reg_arr [NREQ];
    logic [DW-1:0] dat_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign reg_arr[i] = req_reg[i*AW +: AW];
        assign dat_arr[i] = req_data[i*DW +: DW];
    end

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   scan_idx;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [NREQ-1:0] gnt_vec;
    logic [PW-1:0]   next_ptr;
    logic [AW-1:0]   sel_reg;
    logic [DW-1:0]   sel_dat;

    // Scan from rr_ptr upward (wrapping); the first valid requester wins.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_vec  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = PW'((32'(rr_ptr) + k) % NREQ);
            if (!gnt_any && req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign req_ack   = reset ? '0 : gnt_vec;
    assign req_stall = req_valid & ~req_ack;

    assign sel_reg  = reg_arr[gnt_idx];
    assign sel_dat  = dat_arr[gnt_idx];
    assign next_ptr = (gnt_idx == LAST_IDX) ? '0 : PW'(gnt_idx + 1'b1);

    // Register the winner; writes to register 0 are acked but never enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            wr_count  <= '0;
        end else begin
            if (RegWrite && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (gnt_any) begin
                rr_ptr    <= next_ptr;
                WriteReg  <= sel_reg;
                WriteData <= sel_dat;
                RegWrite  <= (sel_reg != '0);
            end else begin
                RegWrite  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps followed by random
// traffic compared against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_reg;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ack;
    logic [NREQ-1:0]     req_stall;
    logic                RegWrite;
    logic [AW-1:0]       WriteReg;
    logic [DW-1:0]       WriteData;
    logic [15:0]         wr_count;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_stall (req_stall),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .wr_count  (wr_count)
    );

    // Register file driven by the arbiter's write port
    logic [DW-1:0] rf [32];
    always @(posedge clock) begin
        if (RegWrite === 1'b1) rf[WriteReg] <= WriteData;
    end

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int            m_ptr = 0;
    logic          m_rw  = 1'b0;
    logic [AW-1:0] m_wr  = '0;
    logic [DW-1:0] m_wd  = '0;
    int            m_cnt = 0;
    bit            known = 1'b0;
    int            cur_g;
    logic [NREQ-1:0] last_ack = '0;

    logic [AW-1:0] rq_reg [NREQ];
    logic [DW-1:0] rq_dat [NREQ];
    bit            pend   [NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int i;
        if (reset) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_reg[i*AW +: AW] = rq_reg[i];
            req_data[i*DW +: DW] = rq_dat[i];
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        rq_reg[i] = r;
        rq_dat[i] = d;
        apply();
    endtask

    // Mid-cycle check of every output against the model
    task automatic check_phase();
        logic [NREQ-1:0] ea;
        @(negedge clock);
        cur_g = model_grant();
        ea = '0;
        if (cur_g >= 0) ea[cur_g] = 1'b1;
        chk("ack", 64'(req_ack), 64'(ea));
        chk("stall", 64'(req_stall), 64'(req_valid & ~ea));
        if (known) begin
            chk("RegWrite", 64'(RegWrite), 64'(m_rw));
            chk("WriteReg", 64'(WriteReg), 64'(m_wr));
            chk("WriteData", 64'(WriteData), 64'(m_wd));
            chk("wr_count", 64'(wr_count), 64'(m_cnt));
        end
        last_ack = req_ack;
    endtask

    // Advance the model across the coming rising edge
    task automatic edge_phase();
        if (reset) begin
            m_ptr = 0; m_rw = 1'b0; m_wr = '0; m_wd = '0; m_cnt = 0;
            known = 1'b1;
        end else begin
            if (m_rw && m_cnt != 65535) m_cnt++;
            if (cur_g >= 0) begin
                m_ptr = (cur_g + 1) % NREQ;
                m_wr  = rq_reg[cur_g];
                m_wd  = rq_dat[cur_g];
                m_rw  = (m_wr != '0);
            end else begin
                m_rw = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            check_phase();
            chk("rst_ack", 64'(req_ack), 64'd0);
            edge_phase();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        req_reg   = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq_reg[i] = AW'(i + 1);
            rq_dat[i] = DW'(32'h100 + i);
            pend[i]   = 1'b0;
        end
        apply();
        #1;

        // Reset with all requesters valid, then first grant goes to requester 0
        do_reset();
        req_valid = '0;
        check_phase();
        chk("post_rst_RegWrite", 64'(RegWrite), 64'd0);
        chk("post_rst_WriteReg", 64'(WriteReg), 64'd0);
        chk("post_rst_WriteData", 64'(WriteData), 64'd0);
        chk("post_rst_wr_count", 64'(wr_count), 64'd0);
        edge_phase();
        req_valid = '1;
        check_phase();
        chk("first_grant", 64'(req_ack), 64'b001);
        edge_phase();

        // Single requester
        req_valid = '1;
        do_reset();
        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        check_phase();
        chk("single_ack", 64'(req_ack), 64'b010);
        edge_phase();
        req_valid = '0;
        check_phase();
        chk("single_RegWrite", 64'(RegWrite), 64'd1);
        chk("single_WriteReg", 64'(WriteReg), 64'd5);
        chk("single_WriteData", 64'(WriteData), 64'hDEADBEEF);
        edge_phase();
        check_phase();
        chk("single_count", 64'(wr_count), 64'd1);
        edge_phase();

        // Round-robin fairness
        do_reset();
        set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            check_phase();
            chk("rr_ack", 64'(req_ack), 64'(1 << (k % 3)));
            if (k > 0) chk("rr_RegWrite", 64'(RegWrite), 64'd1);
            edge_phase();
        end
        req_valid = '0;
        check_phase();
        chk("rr_RegWrite_last", 64'(RegWrite), 64'd1);
        edge_phase();

        // Register 0 write: acked, suppressed, pointer wraps to 0
        do_reset();
        set_req(2, 5'd0, 32'h1234);
        req_valid = 3'b100;
        check_phase();
        chk("r0_ack", 64'(req_ack), 64'b100);
        edge_phase();
        req_valid = '0;
        check_phase();
        chk("r0_RegWrite", 64'(RegWrite), 64'd0);
        edge_phase();
        set_req(2, 5'd3, 32'h33);
        req_valid = '1;
        check_phase();
        chk("r0_count", 64'(wr_count), 64'd0);
        chk("r0_ptr", 64'(req_ack), 64'b001);
        edge_phase();
        req_valid = '0;

        // Same destination: later grant wins
        do_reset();
        set_req(0, 5'd7, 32'hA); set_req(1, 5'd7, 32'hB);
        req_valid = 3'b011;
        check_phase();
        chk("same_ack0", 64'(req_ack), 64'b001);
        edge_phase();
        req_valid = 3'b010;
        check_phase();
        chk("same_ack1", 64'(req_ack), 64'b010);
        edge_phase();
        req_valid = '0;
        check_phase();
        edge_phase();
        check_phase();
        chk("same_rf7", 64'(rf[7]), 64'hB);
        edge_phase();

        // Reset in the cycle after a grant
        do_reset();
        set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
        req_valid = '1;
        check_phase();
        edge_phase();
        check_phase();
        edge_phase();
        reset = 1'b1;
        check_phase();
        chk("mid_rst_RegWrite", 64'(RegWrite), 64'd1);
        edge_phase();
        reset = 1'b0;
        check_phase();
        chk("mid_post_RegWrite", 64'(RegWrite), 64'd0);
        chk("mid_post_ack", 64'(req_ack), 64'b001);
        edge_phase();

        // Random traffic obeying the hold-until-ack rule
        req_valid = '0;
        last_ack  = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && last_ack[i]) pend[i] = 1'b0;
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i]   = 1'b1;
                    rq_reg[i] = AW'($urandom_range(0, 31));
                    rq_dat[i] = DW'($urandom);
                end
                req_valid[i] = pend[i];
            end
            apply();
            reset = ($urandom_range(0, 39) == 0);
            check_phase();
            edge_phase();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
